// File: rtl/gerenciador_requisicao.sv
// gerenciador_requisicao
// Front-end for the sequential calculation core. It takes one operand over a
// valid/ready handshake, starts the core, waits for completion under a
// watchdog, clears the core and hands the result (or a timeout error)
// downstream over a second valid/ready handshake. It also counts completed
// transactions.
module gerenciador_requisicao #(
    parameter int W       = 8,
    parameter int TIMEOUT = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [W-1:0]     in_x,
    output logic [W-1:0]     x_calc,
    output logic             inicio,
    output logic             rst_calc,
    input  logic             pronto,
    input  logic [2*W-1:0]   resultado,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [2*W-1:0]   out_dado,
    output logic             out_erro,
    output logic [7:0]       n_ops
);

    // Watchdog width is ceil(log2(TIMEOUT)), never below one bit.
    localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LIM = CW'(TIMEOUT - 1);
    localparam logic [CW-1:0] CNT_UM  = CW'(1);

    typedef enum logic [2:0] {
        LIVRE   = 3'd0,
        PARTIDA = 3'd1,
        ESPERA  = 3'd2,
        LIMPA   = 3'd3,
        SAIDA   = 3'd4
    } estado_t;

    estado_t         state_r;
    logic [CW-1:0]   cnt_r;

    // Transaction sequencer: state, operand hold, watchdog, result capture and op count.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r  <= LIVRE;
            x_calc   <= {W{1'b0}};
            out_dado <= {(2*W){1'b0}};
            out_erro <= 1'b0;
            n_ops    <= 8'd0;
            cnt_r    <= {CW{1'b0}};
        end else begin
            case (state_r)
                LIVRE: begin
                    // A stale pronto from the core is deliberately ignored here.
                    if (in_valid) begin
                        x_calc  <= in_x;
                        state_r <= PARTIDA;
                    end
                end
                PARTIDA: begin
                    cnt_r   <= {CW{1'b0}};
                    state_r <= ESPERA;
                end
                ESPERA: begin
                    // pronto has priority over an expiring watchdog.
                    if (pronto) begin
                        out_dado <= resultado;
                        out_erro <= 1'b0;
                        state_r  <= LIMPA;
                    end else if (cnt_r == CNT_LIM) begin
                        out_dado <= {(2*W){1'b1}};
                        out_erro <= 1'b1;
                        state_r  <= LIMPA;
                    end else begin
                        cnt_r <= cnt_r + CNT_UM;
                    end
                end
                LIMPA: begin
                    n_ops   <= n_ops + 8'd1;
                    state_r <= SAIDA;
                end
                SAIDA: begin
                    if (out_ready) begin
                        state_r <= LIVRE;
                    end
                end
                default: begin
                    state_r <= LIVRE;
                end
            endcase
        end
    end

    // Handshake and core-control strobes decoded from state; rst also clears the core.
    always_comb begin
        in_ready  = 1'b0;
        inicio    = 1'b0;
        out_valid = 1'b0;
        case (state_r)
            LIVRE:   in_ready  = 1'b1;
            PARTIDA: inicio    = 1'b1;
            SAIDA:   out_valid = 1'b1;
            default: begin
                in_ready  = 1'b0;
                inicio    = 1'b0;
                out_valid = 1'b0;
            end
        endcase
        rst_calc = rst | (state_r == LIMPA);
    end

endmodule
